// File: rtl/uart_mm_pkg.sv
// uart_mm shared definitions.
// Register offsets, STATUS/CTRL bit positions, engine states.
package uart_mm_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RX_OVR   = 4;
    localparam int ST_FERR     = 5;
    localparam int ST_PERR     = 6;
    localparam int ST_TX_OVF   = 7;
    localparam int ST_TX_IDLE  = 8;

    localparam int CT_TX_EN   = 0;
    localparam int CT_RX_EN   = 1;
    localparam int CT_PAR_EN  = 2;
    localparam int CT_PAR_ODD = 3;
    localparam int CT_LOOP    = 4;
    localparam int CT_IRQ_RX  = 5;
    localparam int CT_IRQ_TX  = 6;
    localparam int CT_IRQ_ERR = 7;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_mm_if.sv
// uart_mm memory-mapped bus bundle.
// Master drives the request side, slave returns responses.
interface uart_mm_if;
    logic [29:0] bus_address;
    logic [31:0] bus_writedata;
    logic        bus_write;
    logic        bus_read;
    logic [3:0]  bus_byteenable;
    logic [4:0]  bus_burstcount;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic        s_writeresponsevalid;
    logic [1:0]  s_response;

    modport master (
        output bus_address, bus_writedata, bus_write, bus_read,
        output bus_byteenable, bus_burstcount,
        input  s_waitrequest, s_readdata, s_readdatavalid,
        input  s_writeresponsevalid, s_response
    );

    modport slave (
        input  bus_address, bus_writedata, bus_write, bus_read,
        input  bus_byteenable, bus_burstcount,
        output s_waitrequest, s_readdata, s_readdatavalid,
        output s_writeresponsevalid, s_response
    );
endinterface

// File: rtl/uart_fifo.sv
// uart_mm byte FIFO.
// Extra pointer bit separates full from empty.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign count   = wp - rp;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp[AW-1:0]];

    // pointer advance on accepted push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    // storage write, contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_mm.sv
// uart_mm: memory-mapped UART with TX/RX FIFOs.
// TX and RX bit engines live here; FIFOs are submodules.
module uart_mm
    import uart_mm_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [27:0] BASE_ADDR   = 28'h0F80000,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic      clk,
    input  logic      rst,
    uart_mm_if.slave  bus,
    output logic      irq,
    output logic      all_done,
    output logic      TX,
    input  logic      RX
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel, rd, wr;
    logic [1:0]    off;
    logic [15:0]   div_q, div_new;
    logic [7:0]    ctrl_q;
    logic          rx_ovr, ferr, perr, tx_ovf;
    logic [31:0]   status, rdata;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_dout;
    logic [CW-1:0] tx_cnt;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_dout;
    logic [CW-1:0] rx_cnt;
    logic          unused_bits;

    assign sel = bus.bus_address[29:2] == BASE_ADDR;
    assign off = bus.bus_address[1:0];
    assign rd  = sel && bus.bus_read;
    assign wr  = sel && bus.bus_write;
    assign bus.s_waitrequest = 1'b0;
    assign bus.s_response    = 2'b00;
    assign tx_push = wr && off == OFF_DATA && bus.bus_byteenable[0];
    assign rx_pop  = rd && off == OFF_DATA;
    assign unused_bits = ^{bus.bus_burstcount, bus.bus_writedata[31:16],
                           bus.bus_byteenable[3:2]};

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_txf (
        .clk(clk), .rst(rst), .push(tx_push), .din(bus.bus_writedata[7:0]),
        .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty),
        .count(tx_cnt));

    tx_state_t     tx_st, tx_nx;
    logic [15:0]   tx_c, tx_c_nx, tx_dv, tx_dv_nx;
    logic [2:0]    tx_b, tx_b_nx;
    logic [7:0]    tx_sh, tx_sh_nx;
    logic          tx_p, tx_p_nx, tx_last, tx_line;

    rx_state_t     rx_st, rx_nx;
    logic [15:0]   rx_c, rx_c_nx, rx_dv, rx_dv_nx;
    logic [2:0]    rx_b, rx_b_nx;
    logic [7:0]    rx_sh, rx_sh_nx;
    logic          rx_pb, rx_pb_nx, rx_s1, rx_s2, rx_prev;
    logic          rx_cell, rx_half, rx_fall;
    logic          ovr_set, ferr_set, perr_set;

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rxf (
        .clk(clk), .rst(rst), .push(rx_push), .din(rx_sh),
        .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty),
        .count(rx_cnt));

    assign all_done = tx_empty && tx_st == TX_IDLE;
    assign TX       = ctrl_q[CT_LOOP] ? 1'b1 : tx_line;

    // STATUS word and read-data mux
    always_comb begin
        status = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_FERR]     = ferr;
        status[ST_PERR]     = perr;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_TX_IDLE]  = tx_st == TX_IDLE;
        status[23:16]       = 8'(rx_cnt);
        status[31:24]       = 8'(FIFO_DEPTH) - 8'(tx_cnt);
        div_new = div_q;
        if (bus.bus_byteenable[0]) div_new[7:0]  = bus.bus_writedata[7:0];
        if (bus.bus_byteenable[1]) div_new[15:8] = bus.bus_writedata[15:8];
        rdata = '0;
        unique case (off)
            OFF_DATA:   rdata = {rx_empty, 23'b0, rx_empty ? 8'h00 : rx_dout};
            OFF_STATUS: rdata = status;
            OFF_DIV:    rdata = {16'b0, div_q};
            default:    rdata = {24'b0, ctrl_q};
        endcase
    end

    // bus responses, config registers, sticky flags, irq
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.s_readdatavalid      <= 1'b0;
            bus.s_writeresponsevalid <= 1'b0;
            bus.s_readdata           <= '0;
            div_q  <= DEFAULT_DIV;
            ctrl_q <= 8'h03;
            rx_ovr <= 1'b0;
            ferr   <= 1'b0;
            perr   <= 1'b0;
            tx_ovf <= 1'b0;
            irq    <= 1'b0;
        end else begin
            bus.s_readdatavalid      <= rd;
            bus.s_writeresponsevalid <= wr;
            if (rd) bus.s_readdata <= rdata;
            if (wr && off == OFF_DIV)
                div_q <= (div_new < 16'd4) ? 16'd4 : div_new;
            if (wr && off == OFF_CTRL && bus.bus_byteenable[0])
                ctrl_q <= bus.bus_writedata[7:0];
            if (wr && off == OFF_STATUS && bus.bus_byteenable[0]) begin
                if (bus.bus_writedata[ST_RX_OVR]) rx_ovr <= 1'b0;
                if (bus.bus_writedata[ST_FERR])   ferr   <= 1'b0;
                if (bus.bus_writedata[ST_PERR])   perr   <= 1'b0;
                if (bus.bus_writedata[ST_TX_OVF]) tx_ovf <= 1'b0;
            end
            if (ovr_set)            rx_ovr <= 1'b1;
            if (ferr_set)           ferr   <= 1'b1;
            if (perr_set)           perr   <= 1'b1;
            if (tx_push && tx_full) tx_ovf <= 1'b1;
            irq <= (ctrl_q[CT_IRQ_RX] && !rx_empty)
                 | (ctrl_q[CT_IRQ_TX] && tx_empty)
                 | (ctrl_q[CT_IRQ_ERR] && (rx_ovr | ferr | perr | tx_ovf));
        end
    end

    assign tx_last = tx_c == tx_dv - 16'd1;

    // TX engine state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st <= TX_IDLE;
            tx_c  <= '0;
            tx_dv <= 16'd4;
            tx_b  <= '0;
            tx_sh <= '0;
            tx_p  <= 1'b0;
        end else begin
            tx_st <= tx_nx;
            tx_c  <= tx_c_nx;
            tx_dv <= tx_dv_nx;
            tx_b  <= tx_b_nx;
            tx_sh <= tx_sh_nx;
            tx_p  <= tx_p_nx;
        end
    end

    // TX next state: divisor latched at frame start
    always_comb begin
        tx_nx    = tx_st;
        tx_c_nx  = tx_c;
        tx_dv_nx = tx_dv;
        tx_b_nx  = tx_b;
        tx_sh_nx = tx_sh;
        tx_p_nx  = tx_p;
        tx_pop   = 1'b0;
        if (tx_st != TX_IDLE) tx_c_nx = tx_last ? 16'd0 : tx_c + 16'd1;
        unique case (tx_st)
            TX_IDLE: if (ctrl_q[CT_TX_EN] && !tx_empty) begin
                tx_pop   = 1'b1;
                tx_sh_nx = tx_dout;
                tx_p_nx  = (^tx_dout) ^ ctrl_q[CT_PAR_ODD];
                tx_dv_nx = div_q;
                tx_c_nx  = '0;
                tx_nx    = TX_START;
            end
            TX_START: if (tx_last) begin
                tx_b_nx = '0;
                tx_nx   = TX_DATA;
            end
            TX_DATA: if (tx_last) begin
                tx_sh_nx = tx_sh >> 1;
                tx_b_nx  = tx_b + 3'd1;
                if (tx_b == 3'd7)
                    tx_nx = ctrl_q[CT_PAR_EN] ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (tx_last) tx_nx = TX_STOP;
            TX_STOP:   if (tx_last) tx_nx = TX_IDLE;
            default:   tx_nx = TX_IDLE;
        endcase
    end

    // TX line level per state, high when idle
    always_comb begin
        tx_line = 1'b1;
        unique case (tx_st)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_sh[0];
            TX_PARITY: tx_line = tx_p;
            default:   tx_line = 1'b1;
        endcase
    end

    assign rx_cell = rx_c == rx_dv - 16'd1;
    assign rx_half = rx_c == (rx_dv >> 1) - 16'd1;
    assign rx_fall = rx_prev && !rx_s2;

    // RX synchronizer and engine state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            rx_st   <= RX_IDLE;
            rx_c    <= '0;
            rx_dv   <= 16'd4;
            rx_b    <= '0;
            rx_sh   <= '0;
            rx_pb   <= 1'b0;
        end else begin
            rx_s1   <= ctrl_q[CT_LOOP] ? tx_line : RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_st   <= rx_nx;
            rx_c    <= rx_c_nx;
            rx_dv   <= rx_dv_nx;
            rx_b    <= rx_b_nx;
            rx_sh   <= rx_sh_nx;
            rx_pb   <= rx_pb_nx;
        end
    end

    // RX next state: mid-cell sampling, error/overrun on stop bit
    always_comb begin
        rx_nx    = rx_st;
        rx_c_nx  = rx_c;
        rx_dv_nx = rx_dv;
        rx_b_nx  = rx_b;
        rx_sh_nx = rx_sh;
        rx_pb_nx = rx_pb;
        rx_push  = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        if (rx_st != RX_IDLE) rx_c_nx = rx_c + 16'd1;
        if (!ctrl_q[CT_RX_EN]) begin
            rx_nx = RX_IDLE;
        end else begin
            unique case (rx_st)
                RX_IDLE: if (rx_fall) begin
                    rx_dv_nx = div_q;
                    rx_c_nx  = '0;
                    rx_pb_nx = 1'b0;
                    rx_nx    = RX_START;
                end
                RX_START: if (rx_half) begin
                    rx_c_nx = '0;
                    rx_b_nx = '0;
                    rx_nx   = rx_s2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cell) begin
                    rx_c_nx  = '0;
                    rx_sh_nx = {rx_s2, rx_sh[7:1]};
                    rx_b_nx  = rx_b + 3'd1;
                    if (rx_b == 3'd7)
                        rx_nx = ctrl_q[CT_PAR_EN] ? RX_PARITY : RX_STOP;
                end
                RX_PARITY: if (rx_cell) begin
                    rx_c_nx  = '0;
                    rx_pb_nx = rx_s2 != ((^rx_sh) ^ ctrl_q[CT_PAR_ODD]);
                    rx_nx    = RX_STOP;
                end
                RX_STOP: if (rx_cell) begin
                    rx_nx = RX_IDLE;
                    if (!rx_s2)       ferr_set = 1'b1;
                    else if (rx_pb)   perr_set = 1'b1;
                    else if (rx_full) ovr_set  = 1'b1;
                    else              rx_push  = 1'b1;
                end
                default: rx_nx = RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mm.sv
// uart_mm testbench: scenario tasks with a queue scoreboard.
// Expected values are queued at stimulus time and popped on response.
module tb_uart_mm;
    import uart_mm_pkg::*;

    localparam logic [27:0] BASE = 28'h0F80000;

    logic clk = 1'b0;
    logic rst;
    logic irq, all_done, tx, rx;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  rx_q[$];

    uart_mm_if bus();

    uart_mm #(
        .FIFO_DEPTH(8), .BASE_ADDR(BASE), .DEFAULT_DIV(16'd434)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .irq(irq),
        .all_done(all_done), .TX(tx), .RX(rx)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic bus_rd(input logic [29:0] a, output logic [31:0] d,
                          output logic v);
        @(negedge clk);
        bus.bus_address = a;
        bus.bus_read    = 1'b1;
        @(negedge clk);
        bus.bus_read = 1'b0;
        d = bus.s_readdata;
        v = bus.s_readdatavalid;
    endtask

    task automatic bus_wr(input logic [1:0] o, input logic [31:0] wd,
                          input logic [3:0] be, output logic wv);
        @(negedge clk);
        bus.bus_address    = {BASE, o};
        bus.bus_writedata  = wd;
        bus.bus_byteenable = be;
        bus.bus_write      = 1'b1;
        @(negedge clk);
        bus.bus_write = 1'b0;
        wv = bus.s_writeresponsevalid;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic pen,
                               input logic pbit, input logic stop);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (4) @(negedge clk);
        end
        if (pen) begin
            rx = pbit;
            repeat (4) @(negedge clk);
        end
        rx = stop;
        repeat (4) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        logic v;
        rst = 1'b1;
        rx  = 1'b1;
        bus.bus_address = '0;
        bus.bus_writedata = '0;
        bus.bus_write = 1'b0;
        bus.bus_read = 1'b0;
        bus.bus_byteenable = 4'h0;
        bus.bus_burstcount = 5'd1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx, irq, all_done} !== 3'b101) begin
            n_bad++;
            $display("FAIL rst_pins got tx/irq/done=%b need 101",
                     {tx, irq, all_done});
        end
        n_cmp++;
        if ({bus.s_readdatavalid, bus.s_writeresponsevalid,
             bus.s_readdata} !== 34'b0) begin
            n_bad++;
            $display("FAIL rst_resp got %b %b %h need 0 0 0",
                     bus.s_readdatavalid, bus.s_writeresponsevalid,
                     bus.s_readdata);
        end
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(32'h3);
        bus_rd({BASE, OFF_CTRL}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (v !== 1'b1 || d !== e) begin
            n_bad++;
            $display("FAIL ctrl_rst got v=%b %h need v=1 %h", v, d, e);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.s_readdatavalid !== 1'b0) begin
            n_bad++;
            $display("FAIL rvalid_pulse got %b need 0", bus.s_readdatavalid);
        end
        exp_q.push_back(32'd434);
        bus_rd({BASE, OFF_DIV}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (v !== 1'b1 || d !== e) begin
            n_bad++;
            $display("FAIL div_rst got v=%b %h need v=1 %h", v, d, e);
        end
        exp_q.push_back(32'h0800_0106);
        bus_rd({BASE, OFF_STATUS}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (v !== 1'b1 || d !== e) begin
            n_bad++;
            $display("FAIL status_rst got v=%b %h need v=1 %h", v, d, e);
        end
        bus_rd({BASE + 28'd1, OFF_CTRL}, d, v);
        n_cmp++;
        if (v !== 1'b0) begin
            n_bad++;
            $display("FAIL unsel_rd got valid %b need 0", v);
        end
        bus_wr(OFF_DIV, 32'h1, 4'h3, v);
        n_cmp++;
        if (v !== 1'b1) begin
            n_bad++;
            $display("FAIL wresp got %b need 1", v);
        end
        exp_q.push_back(32'd4);
        bus_rd({BASE, OFF_DIV}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL div_clamp got %h need %h", d, e);
        end
    endtask

    task automatic test_loopback();
        logic [31:0] d, e;
        logic v, pin_bad;
        logic [7:0] bytes [3];
        logic [7:0] ctrls [3];
        bytes = '{8'hA5, 8'h3C, 8'h00};
        ctrls = '{8'h13, 8'h17, 8'h1F};
        bus_wr(OFF_CTRL, 32'h13, 4'h1, v);
        exp_q.push_back(32'h8000_0000);
        bus_rd({BASE, OFF_DATA}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL lb_empty got %h need %h", d, e);
        end
        for (int k = 0; k < 3; k++) begin
            bus_wr(OFF_CTRL, {24'b0, ctrls[k]}, 4'h1, v);
            bus_wr(OFF_DATA, {24'b0, bytes[k]}, 4'h1, v);
            exp_q.push_back({24'b0, bytes[k]});
            pin_bad = 1'b0;
            repeat (60) begin
                @(negedge clk);
                if (tx !== 1'b1) pin_bad = 1'b1;
            end
            n_cmp++;
            if (pin_bad !== 1'b0) begin
                n_bad++;
                $display("FAIL lb_pin_%0d got toggling need high", k);
            end
            bus_rd({BASE, OFF_DATA}, d, v);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin
                n_bad++;
                $display("FAIL lb_data_%0d got %h need %h", k, d, e);
            end
        end
    endtask

    task automatic test_tx_pin();
        logic [31:0] e;
        logic v;
        logic [7:0] b;
        int t;
        b = 8'h5A;
        bus_wr(OFF_CTRL, 32'h01, 4'h1, v);
        bus_wr(OFF_DATA, {24'b0, b}, 4'h1, v);
        exp_q.push_back(32'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back({31'b0, b[i]});
        exp_q.push_back(32'd1);
        t = 0;
        while (tx !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (tx !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_start got no start bit need 0");
            exp_q.delete();
        end else begin
            @(negedge clk);
            for (int k = 0; k < 10; k++) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (tx !== e[0]) begin
                    n_bad++;
                    $display("FAIL tx_bit_%0d got %b need %b", k, tx, e[0]);
                end
                repeat (4) @(negedge clk);
            end
        end
        n_cmp++;
        if (all_done !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_done got %b need 1", all_done);
        end
    endtask

    task automatic test_tx_ovf();
        logic [31:0] d, e;
        logic v;
        int t;
        bus_wr(OFF_CTRL, 32'h00, 4'h1, v);
        for (int i = 0; i < 9; i++)
            bus_wr(OFF_DATA, 32'h10 + i, 4'h1, v);
        exp_q.push_back(32'h0000_0185);
        bus_rd({BASE, OFF_STATUS}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL ovf_status got %h need %h", d, e);
        end
        n_cmp++;
        if (all_done !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_done got %b need 0", all_done);
        end
        bus_wr(OFF_STATUS, 32'h80, 4'hF, v);
        exp_q.push_back(32'h0000_0105);
        bus_rd({BASE, OFF_STATUS}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL ovf_clear got %h need %h", d, e);
        end
        bus_wr(OFF_CTRL, 32'h11, 4'h1, v);
        t = 0;
        @(negedge clk);
        while (all_done !== 1'b1 && t < 800) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (all_done !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_done got %b need 1", all_done);
        end
    endtask

    task automatic test_rx_errors();
        logic [31:0] d, e;
        logic v;
        logic [7:0] b;
        bus_wr(OFF_CTRL, 32'h8E, 4'h1, v);
        drive_frame(8'h01, 1'b1, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        exp_q.push_back(32'h0800_0146);
        bus_rd({BASE, OFF_STATUS}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL perr_status got %h need %h", d, e);
        end
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL perr_irq got %b need 1", irq);
        end
        bus_wr(OFF_STATUS, 32'hF0, 4'hF, v);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_clear got %b need 0", irq);
        end
        bus_wr(OFF_CTRL, 32'h02, 4'h1, v);
        drive_frame(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        exp_q.push_back(32'h0800_0126);
        bus_rd({BASE, OFF_STATUS}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL ferr_status got %h need %h", d, e);
        end
        bus_wr(OFF_STATUS, 32'hF0, 4'hF, v);
        for (int i = 0; i < 9; i++) begin
            b = 8'h30 + 8'(i * 7);
            if (i < 8) rx_q.push_back(b);
            drive_frame(b, 1'b0, 1'b0, 1'b1);
        end
        repeat (10) @(negedge clk);
        exp_q.push_back(32'h0808_011A);
        bus_rd({BASE, OFF_STATUS}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL rxovr_status got %h need %h", d, e);
        end
        for (int i = 0; i < 8; i++) begin
            bus_rd({BASE, OFF_DATA}, d, v);
            b = rx_q.pop_front();
            n_cmp++;
            if (d !== {24'b0, b}) begin
                n_bad++;
                $display("FAIL rx_data_%0d got %h need %h", i, d, b);
            end
        end
        exp_q.push_back(32'h8000_0000);
        bus_rd({BASE, OFF_DATA}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL rx_drained got %h need %h", d, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, e;
        logic v, pin_bad;
        bus_wr(OFF_CTRL, 32'h01, 4'h1, v);
        bus_wr(OFF_DATA, 32'h00, 4'h1, v);
        repeat (12) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_data got tx %b need 0", tx);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_rst_tx got %b need 1", tx);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (all_done !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_rst_done got %b need 1", all_done);
        end
        pin_bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) pin_bad = 1'b1;
        end
        n_cmp++;
        if (pin_bad !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_quiet got activity need high");
        end
        exp_q.push_back(32'h3);
        bus_rd({BASE, OFF_CTRL}, d, v);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL mid_rst_ctrl got %h need %h", d, e);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_tx_pin();
        test_tx_ovf();
        test_rx_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
